// File: rtl/sm_serial_pkg.sv
// Shared types and sizing helpers for the single-wire serial receiver.
// Counter widths are derived from the module parameters via constant functions.
package sm_serial_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BIT_TICKS  = 4;

  function automatic int half_ticks(input int bit_ticks);
    return bit_ticks / 2;
  endfunction

  // A counter over 0..n-1 needs at least one bit even when n == 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sm_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// The reset value lets idle-high and idle-low lines both come out of reset quietly.
module sm_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/sm_serial_rx.sv
// Receive side of the single-wire serial link: start/data/parity/stop frames in,
// parallel words out on a valid/ready port with a one-entry holding buffer.
module sm_serial_rx
  import sm_serial_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BIT_TICKS  = DEF_BIT_TICKS,
  parameter int PARITY_EN  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  overrun,
  output state_e                dbg_state
);

  // Output handshake: a word moves on any rising edge where out_valid && out_ready;
  // while out_valid && !out_ready, out_data and out_valid hold their values.

  localparam int HALF = half_ticks(BIT_TICKS);
  localparam int TW   = cnt_width(BIT_TICKS);
  localparam int BW   = cnt_width(DATA_WIDTH);

  localparam logic [TW-1:0] TICK_MID  = TW'(HALF - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  logic rx_s;

  sm_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  state_e                state_q,      state_d;
  logic [TW-1:0]         tick_cnt_q,   tick_cnt_d;
  logic [BW-1:0]         bit_cnt_q,    bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q,      shift_d;
  logic                  par_q,        par_d;
  logic [DATA_WIDTH-1:0] out_data_q,   out_data_d;
  logic                  out_valid_q,  out_valid_d;
  logic                  frame_err_q,  frame_err_d;
  logic                  parity_err_q, parity_err_d;
  logic                  overrun_q,    overrun_d;

  logic [DATA_WIDTH-1:0] msb_in;
  logic                  par_bad;

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;

    msb_in               = '0;
    msb_in[DATA_WIDTH-1] = rx_s;
    // par_q accumulates data XOR parity bit; only meaningful with a parity bit.
    par_bad              = (PARITY_EN != 0) && par_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      START: begin
        if (tick_cnt_q == TICK_MID) begin
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          par_d      = 1'b0;
          state_d    = rx_s ? IDLE : DATA;
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (tick_cnt_q == TICK_LAST) begin
          tick_cnt_d = '0;
          shift_d    = (shift_q >> 1) | msb_in;
          par_d      = par_q ^ rx_s;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end

      PARITY: begin
        if (tick_cnt_q == TICK_LAST) begin
          tick_cnt_d = '0;
          par_d      = par_q ^ rx_s;
          state_d    = STOP;
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (tick_cnt_q == TICK_LAST) begin
          tick_cnt_d   = '0;
          frame_err_d  = !rx_s;
          parity_err_d = par_bad;
          if (rx_s) begin
            state_d = IDLE;
            if (!par_bad) begin
              // A word leaving this same cycle frees the buffer for the new one.
              if (!out_valid_q || out_ready) begin
                out_data_d  = shift_q;
                out_valid_d = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end
          end else begin
            state_d = WAIT_HIGH;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end

      WAIT_HIGH: begin
        tick_cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d    = IDLE;
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign dbg_state  = state_q;

endmodule
